// File: rtl/core_types_pkg.sv
// Shared MDU issue-queue types: sizing constants, MDU op encodings and the queue entry record.
package core_types_pkg;
  localparam int MDU_IQ_ENTRIES     = 4;
  localparam int LOG_PR_COUNT       = 7;
  localparam int LOG_ROB_ENTRIES    = 6;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;
  localparam int UPPER_PR_W         = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;

  // op[2] selects the divider; op[0] is the unsigned variant for div-family ops
  localparam logic [2:0] MDU_OP_MUL    = 3'b000;
  localparam logic [2:0] MDU_OP_MULH   = 3'b001;
  localparam logic [2:0] MDU_OP_MULHSU = 3'b010;
  localparam logic [2:0] MDU_OP_MULHU  = 3'b011;
  localparam logic [2:0] MDU_OP_DIV    = 3'b100;
  localparam logic [2:0] MDU_OP_DIVU   = 3'b101;
  localparam logic [2:0] MDU_OP_REM    = 3'b110;
  localparam logic [2:0] MDU_OP_REMU   = 3'b111;

  typedef struct packed {
    logic                       valid;
    logic [2:0]                 op;
    logic [LOG_PR_COUNT-1:0]    A_PR;
    logic                       A_ready;
    logic                       A_is_zero;
    logic [LOG_PR_COUNT-1:0]    B_PR;
    logic                       B_ready;
    logic                       B_is_zero;
    logic [LOG_PR_COUNT-1:0]    dest_PR;
    logic [LOG_ROB_ENTRIES-1:0] ROB_index;
  } mdu_iq_entry_t;
endpackage

// File: rtl/mdu_iq_if.sv
// Dispatch, writeback-snoop, issue and PRF-request signals of the MDU issue queue.
interface mdu_iq_if;
  import core_types_pkg::*;

  logic                                        dispatch_valid;
  logic [2:0]                                  dispatch_op;
  logic [LOG_PR_COUNT-1:0]                     dispatch_A_PR;
  logic [LOG_PR_COUNT-1:0]                     dispatch_B_PR;
  logic                                        dispatch_A_ready;
  logic                                        dispatch_B_ready;
  logic                                        dispatch_A_is_zero;
  logic                                        dispatch_B_is_zero;
  logic [LOG_PR_COUNT-1:0]                     dispatch_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]                  dispatch_ROB_index;
  logic                                        dispatch_ready;
  logic [PRF_BANK_COUNT-1:0]                   WB_bus_valid_by_bank;
  logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0]   WB_bus_upper_PR_by_bank;
  logic                                        issue_valid;
  logic [2:0]                                  issue_op;
  logic                                        issue_A_forward;
  logic                                        issue_A_is_zero;
  logic [LOG_PR_COUNT-1:0]                     issue_A_PR;
  logic                                        issue_B_forward;
  logic                                        issue_B_is_zero;
  logic [LOG_PR_COUNT-1:0]                     issue_B_PR;
  logic [LOG_PR_COUNT-1:0]                     issue_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]                  issue_ROB_index;
  logic                                        issue_ready;
  logic                                        PRF_A_req_valid;
  logic [LOG_PR_COUNT-1:0]                     PRF_A_req_PR;
  logic                                        PRF_B_req_valid;
  logic [LOG_PR_COUNT-1:0]                     PRF_B_req_PR;

  modport slave (
    input  dispatch_valid, dispatch_op, dispatch_A_PR, dispatch_B_PR, dispatch_A_ready,
           dispatch_B_ready, dispatch_A_is_zero, dispatch_B_is_zero, dispatch_dest_PR,
           dispatch_ROB_index, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank, issue_ready,
    output dispatch_ready, issue_valid, issue_op, issue_A_forward, issue_A_is_zero, issue_A_PR,
           issue_B_forward, issue_B_is_zero, issue_B_PR, issue_dest_PR, issue_ROB_index,
           PRF_A_req_valid, PRF_A_req_PR, PRF_B_req_valid, PRF_B_req_PR
  );

  modport master (
    output dispatch_valid, dispatch_op, dispatch_A_PR, dispatch_B_PR, dispatch_A_ready,
           dispatch_B_ready, dispatch_A_is_zero, dispatch_B_is_zero, dispatch_dest_PR,
           dispatch_ROB_index, WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank, issue_ready,
    input  dispatch_ready, issue_valid, issue_op, issue_A_forward, issue_A_is_zero, issue_A_PR,
           issue_B_forward, issue_B_is_zero, issue_B_PR, issue_dest_PR, issue_ROB_index,
           PRF_A_req_valid, PRF_A_req_PR, PRF_B_req_valid, PRF_B_req_PR
  );
endinterface

// File: rtl/mdu_iq_wakeup.sv
// Combinational match of one source PR against the writeback bus of the bank it lives in.
module mdu_iq_wakeup
  import core_types_pkg::*;
(
  input  logic [LOG_PR_COUNT-1:0]                   PR,
  input  logic [PRF_BANK_COUNT-1:0]                 WB_bus_valid_by_bank,
  input  logic [PRF_BANK_COUNT-1:0][UPPER_PR_W-1:0] WB_bus_upper_PR_by_bank,
  output logic                                      wake_now
);
  logic [LOG_PRF_BANK_COUNT-1:0] bank;

  assign bank     = PR[LOG_PRF_BANK_COUNT-1:0];
  assign wake_now = WB_bus_valid_by_bank[bank] &
                    (WB_bus_upper_PR_by_bank[bank] == PR[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
endmodule

// File: rtl/mdu_iq.sv
// MDU issue queue: compressing oldest-first queue with writeback wakeup and PRF read requests.
// Define MDU_IQ_DIV_GROUPING_EN to prefer divs whose operands match the last issued div.
module mdu_iq #(
  parameter int MDU_IQ_ENTRIES     = core_types_pkg::MDU_IQ_ENTRIES,
  parameter int LOG_MDU_IQ_ENTRIES = $clog2(MDU_IQ_ENTRIES)
) (
  input  logic    CLK,
  input  logic    RST,
  mdu_iq_if.slave io
);
  import core_types_pkg::*;

  // one extra bit so the counter can hold the full depth
  localparam int CW = LOG_MDU_IQ_ENTRIES + 1;

  mdu_iq_entry_t                 q      [MDU_IQ_ENTRIES];
  mdu_iq_entry_t                 q_next [MDU_IQ_ENTRIES];
  mdu_iq_entry_t                 upd    [MDU_IQ_ENTRIES+1];
  mdu_iq_entry_t                 new_e;
  mdu_iq_entry_t                 sel_e;
  logic [CW-1:0]                 count, count_next, wr_idx;
  logic [MDU_IQ_ENTRIES-1:0]     wake_A, wake_B, elig, pick;
  logic [LOG_MDU_IQ_ENTRIES-1:0] sel;
  logic                          disp_wake_A, disp_wake_B;
  logic                          issue_vld, issue_fire, disp_fire;
  logic                          sel_wake_A, sel_wake_B, fwd_A, fwd_B;

  for (genvar i = 0; i < MDU_IQ_ENTRIES; i++) begin : g_wake
    mdu_iq_wakeup u_wake_A (
      .PR                      (q[i].A_PR),
      .WB_bus_valid_by_bank    (io.WB_bus_valid_by_bank),
      .WB_bus_upper_PR_by_bank (io.WB_bus_upper_PR_by_bank),
      .wake_now                (wake_A[i])
    );
    mdu_iq_wakeup u_wake_B (
      .PR                      (q[i].B_PR),
      .WB_bus_valid_by_bank    (io.WB_bus_valid_by_bank),
      .WB_bus_upper_PR_by_bank (io.WB_bus_upper_PR_by_bank),
      .wake_now                (wake_B[i])
    );
    assign elig[i] = q[i].valid &
                     (q[i].A_ready | q[i].A_is_zero | wake_A[i]) &
                     (q[i].B_ready | q[i].B_is_zero | wake_B[i]);
  end

  mdu_iq_wakeup u_disp_wake_A (
    .PR                      (io.dispatch_A_PR),
    .WB_bus_valid_by_bank    (io.WB_bus_valid_by_bank),
    .WB_bus_upper_PR_by_bank (io.WB_bus_upper_PR_by_bank),
    .wake_now                (disp_wake_A)
  );
  mdu_iq_wakeup u_disp_wake_B (
    .PR                      (io.dispatch_B_PR),
    .WB_bus_valid_by_bank    (io.WB_bus_valid_by_bank),
    .WB_bus_upper_PR_by_bank (io.WB_bus_upper_PR_by_bank),
    .wake_now                (disp_wake_B)
  );

`ifdef MDU_IQ_DIV_GROUPING_EN
  logic                      grp_vld, grp_op0;
  logic [LOG_PR_COUNT-1:0]   grp_A_PR, grp_B_PR;
  logic [MDU_IQ_ENTRIES-1:0] grp_hit;

  for (genvar i = 0; i < MDU_IQ_ENTRIES; i++) begin : g_grp
    assign grp_hit[i] = elig[i] & q[i].op[2] & grp_vld & (q[i].A_PR == grp_A_PR) &
                        (q[i].B_PR == grp_B_PR) & (q[i].op[0] == grp_op0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      grp_vld  <= 1'b0;
      grp_op0  <= 1'b0;
      grp_A_PR <= '0;
      grp_B_PR <= '0;
    end else if (issue_fire) begin
      grp_vld <= sel_e.op[2];
      if (sel_e.op[2]) begin
        grp_op0  <= sel_e.op[0];
        grp_A_PR <= sel_e.A_PR;
        grp_B_PR <= sel_e.B_PR;
      end
    end
  end

  assign pick = (|grp_hit) ? grp_hit : elig;
`else
  assign pick = elig;
`endif

  // lowest set index of pick, i.e. the oldest candidate
  always_comb begin
    sel = '0;
    for (int i = MDU_IQ_ENTRIES - 1; i >= 0; i--) begin
      if (pick[i]) sel = LOG_MDU_IQ_ENTRIES'(i);
    end
  end

  assign issue_vld  = |elig;
  assign issue_fire = issue_vld & io.issue_ready;
  assign disp_fire  = io.dispatch_valid & io.dispatch_ready;
  assign sel_e      = issue_vld ? q[sel] : '0;
  assign sel_wake_A = issue_vld & wake_A[sel];
  assign sel_wake_B = issue_vld & wake_B[sel];
  assign fwd_A      = sel_wake_A & ~sel_e.A_ready & ~sel_e.A_is_zero;
  assign fwd_B      = sel_wake_B & ~sel_e.B_ready & ~sel_e.B_is_zero;

  assign io.dispatch_ready   = (count != CW'(MDU_IQ_ENTRIES));
  assign io.issue_valid      = issue_vld;
  assign io.issue_op         = sel_e.op;
  assign io.issue_A_forward  = fwd_A;
  assign io.issue_A_is_zero  = sel_e.A_is_zero;
  assign io.issue_A_PR       = sel_e.A_PR;
  assign io.issue_B_forward  = fwd_B;
  assign io.issue_B_is_zero  = sel_e.B_is_zero;
  assign io.issue_B_PR       = sel_e.B_PR;
  assign io.issue_dest_PR    = sel_e.dest_PR;
  assign io.issue_ROB_index  = sel_e.ROB_index;
  assign io.PRF_A_req_valid  = issue_fire & ~sel_e.A_is_zero & ~fwd_A;
  assign io.PRF_A_req_PR     = sel_e.A_PR;
  assign io.PRF_B_req_valid  = issue_fire & ~sel_e.B_is_zero & ~fwd_B;
  assign io.PRF_B_req_PR     = sel_e.B_PR;

  always_comb begin
    new_e           = '0;
    new_e.valid     = 1'b1;
    new_e.op        = io.dispatch_op;
    new_e.A_PR      = io.dispatch_A_PR;
    new_e.A_ready   = io.dispatch_A_ready | disp_wake_A;
    new_e.A_is_zero = io.dispatch_A_is_zero;
    new_e.B_PR      = io.dispatch_B_PR;
    new_e.B_ready   = io.dispatch_B_ready | disp_wake_B;
    new_e.B_is_zero = io.dispatch_B_is_zero;
    new_e.dest_PR   = io.dispatch_dest_PR;
    new_e.ROB_index = io.dispatch_ROB_index;
  end

  assign wr_idx     = issue_fire ? count - CW'(1) : count;
  assign count_next = count + CW'(disp_fire) - CW'(issue_fire);

  // latch wakeups, compress over the issued slot, then drop the new op on top
  always_comb begin
    for (int i = 0; i < MDU_IQ_ENTRIES; i++) begin
      upd[i]         = q[i];
      upd[i].A_ready = q[i].A_ready | wake_A[i];
      upd[i].B_ready = q[i].B_ready | wake_B[i];
    end
    upd[MDU_IQ_ENTRIES] = '0;
    for (int i = 0; i < MDU_IQ_ENTRIES; i++) begin
      q_next[i] = (issue_fire && i >= int'(sel)) ? upd[i+1] : upd[i];
      if (disp_fire && wr_idx == CW'(i)) q_next[i] = new_e;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < MDU_IQ_ENTRIES; i++) q[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < MDU_IQ_ENTRIES; i++) q[i] <= q_next[i];
      count <= count_next;
    end
  end
endmodule

// File: tb/tb_mdu_iq.sv
// Scoreboard bench for mdu_iq: expected issues are queued at dispatch and compared as they fire.
module tb_mdu_iq;
  import core_types_pkg::*;

  typedef struct packed {
    logic [2:0]                 op;
    logic [LOG_PR_COUNT-1:0]    a, b;
    logic                       fa, fb, za, zb;
    logic [LOG_PR_COUNT-1:0]    dest;
    logic [LOG_ROB_ENTRIES-1:0] rob;
    logic                       pav, pbv;
    logic [LOG_PR_COUNT-1:0]    pap, pbp;
  } rec_t;

  logic CLK = 1'b0;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;
  rec_t sb[$];

  always #5 CLK = ~CLK;

  mdu_iq_if bus ();
  mdu_iq dut (.CLK(CLK), .RST(RST), .io(bus));

  function automatic rec_t mk(input logic [2:0] op, input int a, input int b, input logic fa,
                              input logic fb, input logic za, input logic zb, input int dest,
                              input int rob);
    rec_t r;
    r.op   = op;
    r.a    = LOG_PR_COUNT'(a);
    r.b    = LOG_PR_COUNT'(b);
    r.fa   = fa;
    r.fb   = fb;
    r.za   = za;
    r.zb   = zb;
    r.dest = LOG_PR_COUNT'(dest);
    r.rob  = LOG_ROB_ENTRIES'(rob);
    r.pav  = ~za & ~fa;
    r.pbv  = ~zb & ~fb;
    r.pap  = r.a;
    r.pbp  = r.b;
    return r;
  endfunction

  function automatic rec_t obs();
    rec_t r;
    r.op   = bus.issue_op;
    r.a    = bus.issue_A_PR;
    r.b    = bus.issue_B_PR;
    r.fa   = bus.issue_A_forward;
    r.fb   = bus.issue_B_forward;
    r.za   = bus.issue_A_is_zero;
    r.zb   = bus.issue_B_is_zero;
    r.dest = bus.issue_dest_PR;
    r.rob  = bus.issue_ROB_index;
    r.pav  = bus.PRF_A_req_valid;
    r.pbv  = bus.PRF_B_req_valid;
    r.pap  = bus.PRF_A_req_PR;
    r.pbp  = bus.PRF_B_req_PR;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.dispatch_valid          = 1'b0;
    bus.dispatch_op             = '0;
    bus.dispatch_A_PR           = '0;
    bus.dispatch_B_PR           = '0;
    bus.dispatch_A_ready        = 1'b0;
    bus.dispatch_B_ready        = 1'b0;
    bus.dispatch_A_is_zero      = 1'b0;
    bus.dispatch_B_is_zero      = 1'b0;
    bus.dispatch_dest_PR        = '0;
    bus.dispatch_ROB_index      = '0;
    bus.WB_bus_valid_by_bank    = '0;
    bus.WB_bus_upper_PR_by_bank = '0;
  endtask

  task automatic set_disp(input logic [2:0] op, input int a, input int b, input logic ar,
                          input logic br, input logic az, input logic bz, input int dest,
                          input int rob);
    bus.dispatch_valid     = 1'b1;
    bus.dispatch_op        = op;
    bus.dispatch_A_PR      = LOG_PR_COUNT'(a);
    bus.dispatch_B_PR      = LOG_PR_COUNT'(b);
    bus.dispatch_A_ready   = ar;
    bus.dispatch_B_ready   = br;
    bus.dispatch_A_is_zero = az;
    bus.dispatch_B_is_zero = bz;
    bus.dispatch_dest_PR   = LOG_PR_COUNT'(dest);
    bus.dispatch_ROB_index = LOG_ROB_ENTRIES'(rob);
  endtask

  // Waits (bounded) for a cycle in which an issue fires; returns in that cycle, before the edge.
  task automatic wait_issue(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      #1;
      if (bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    idle();
    bus.issue_ready = 1'b1;
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    #1;
    n_tests++;
    if (bus.dispatch_ready !== 1'b1 || bus.issue_valid !== 1'b0 ||
        bus.PRF_A_req_valid !== 1'b0 || bus.PRF_B_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy=%b iv=%b pa=%b pb=%b, required 1 0 0 0",
               bus.dispatch_ready, bus.issue_valid, bus.PRF_A_req_valid, bus.PRF_B_req_valid);
    end
    n_tests++;
    if (obs() !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h, required 0", obs());
    end
    // reset with work pending drops it all
    bus.issue_ready = 1'b0;
    set_disp(MDU_OP_MUL, 1, 2, 1, 1, 0, 0, 3, 4);
    tick();
    set_disp(MDU_OP_MULH, 2, 3, 1, 1, 0, 0, 4, 5);
    tick();
    idle();
    #1;
    n_tests++;
    if (bus.issue_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_before_reset: got issue_valid=%b, required 1", bus.issue_valid);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    bus.issue_ready = 1'b1;
    #1;
    n_tests++;
    if (bus.issue_valid !== 1'b0 || bus.PRF_A_req_valid !== 1'b0 ||
        bus.PRF_B_req_valid !== 1'b0 || bus.dispatch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_reset: got iv=%b pa=%b pb=%b rdy=%b, required 0 0 0 1",
               bus.issue_valid, bus.PRF_A_req_valid, bus.PRF_B_req_valid, bus.dispatch_ready);
    end
    tick();
  endtask

  task automatic test_mul_basic();
    bit   ok;
    rec_t exp, got;
    bus.issue_ready = 1'b1;
    set_disp(MDU_OP_MUL, 5, 9, 1, 1, 0, 0, 20, 1);
    sb.push_back(mk(MDU_OP_MUL, 5, 9, 0, 0, 0, 0, 20, 1));
    #1;
    n_tests++;
    if (bus.issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_same_cycle: got issue_valid=%b, required 0", bus.issue_valid);
    end
    tick();
    idle();
    wait_issue(1, ok);
    exp = sb.pop_front();
    got = obs();
    n_tests++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL mul_issue: fired=%b got %h, required %h", ok, got, exp);
    end
    tick();
    n_tests++;
    if (dut.count !== 0 || bus.issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_drained: got count=%0d iv=%b, required 0 0", dut.count, bus.issue_valid);
    end
  endtask

  task automatic test_div_wakeup();
    bit   ok;
    rec_t exp, got;
    bus.issue_ready = 1'b1;
    set_disp(MDU_OP_DIV, 3, 14, 1, 0, 0, 0, 21, 2);
    sb.push_back(mk(MDU_OP_DIV, 3, 14, 0, 1, 0, 0, 21, 2));
    tick();
    idle();
    // bank 2 writes back PR 18 (upper 4), not PR 14
    bus.WB_bus_valid_by_bank       = 4'b0100;
    bus.WB_bus_upper_PR_by_bank[2] = UPPER_PR_W'(4);
    #1;
    n_tests++;
    if (bus.issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL div_wrong_wb: got issue_valid=%b, required 0", bus.issue_valid);
    end
    tick();
    bus.WB_bus_upper_PR_by_bank[2] = UPPER_PR_W'(14 >> 2);
    wait_issue(1, ok);
    exp = sb.pop_front();
    got = obs();
    n_tests++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL div_wake_forward: fired=%b got %h, required %h", ok, got, exp);
    end
    tick();
    // operand woken in its own dispatch cycle is captured as ready, not forwarded later
    set_disp(MDU_OP_DIVU, 2, 18, 1, 0, 0, 0, 22, 3);
    bus.WB_bus_valid_by_bank       = 4'b0100;
    bus.WB_bus_upper_PR_by_bank[2] = UPPER_PR_W'(18 >> 2);
    sb.push_back(mk(MDU_OP_DIVU, 2, 18, 0, 0, 0, 0, 22, 3));
    tick();
    idle();
    wait_issue(1, ok);
    exp = sb.pop_front();
    got = obs();
    n_tests++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL dispatch_wakeup: fired=%b got %h, required %h", ok, got, exp);
    end
    tick();
  endtask

  task automatic test_full();
    bit   ok;
    rec_t exp, got;
    bus.issue_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      set_disp(3'(r), r + 1, r + 2, 1, 1, 0, 0, 30 + r, r);
      sb.push_back(mk(3'(r), r + 1, r + 2, 0, 0, 0, 0, 30 + r, r));
      tick();
    end
    idle();
    #1;
    n_tests++;
    if (bus.dispatch_ready !== 1'b0 || bus.issue_valid !== 1'b1 ||
        bus.PRF_A_req_valid !== 1'b0 || bus.PRF_B_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_stall: got rdy=%b iv=%b pa=%b pb=%b, required 0 1 0 0",
               bus.dispatch_ready, bus.issue_valid, bus.PRF_A_req_valid, bus.PRF_B_req_valid);
    end
    set_disp(MDU_OP_MUL, 40, 41, 1, 1, 0, 0, 42, 9);
    tick();
    idle();
    n_tests++;
    if (dut.count !== 4) begin
      n_fail++;
      $display("FAIL full_ignore: got count=%0d, required 4", dut.count);
    end
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_issue(1, ok);
      exp = sb.pop_front();
      got = obs();
      n_tests++;
      if (!ok || got !== exp) begin
        n_fail++;
        $display("FAIL full_order_%0d: fired=%b got %h, required %h", k, ok, got, exp);
      end
      tick();
    end
    n_tests++;
    if (bus.issue_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_fifth_dropped: got issue_valid=%b, required 0", bus.issue_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit   ok;
    rec_t exp, got;
    bus.issue_ready = 1'b0;
    for (int r = 10; r < 13; r++) begin
      set_disp(MDU_OP_MULHU, r, r + 20, 1, 1, 0, 0, r + 50, r);
      sb.push_back(mk(MDU_OP_MULHU, r, r + 20, 0, 0, 0, 0, r + 50, r));
      tick();
    end
    set_disp(MDU_OP_REMU, 13, 33, 1, 1, 0, 0, 63, 13);
    bus.issue_ready = 1'b1;
    wait_issue(1, ok);
    exp = sb.pop_front();
    got = obs();
    n_tests++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL b2b_issue: fired=%b got %h, required %h", ok, got, exp);
    end
    sb.push_back(mk(MDU_OP_REMU, 13, 33, 0, 0, 0, 0, 63, 13));
    tick();
    idle();
    n_tests++;
    if (dut.count !== 3 || dut.q[2].ROB_index !== 6'd13) begin
      n_fail++;
      $display("FAIL b2b_slot: got count=%0d slot2_rob=%0d, required 3 13",
               dut.count, dut.q[2].ROB_index);
    end
    for (int k = 0; k < 3; k++) begin
      wait_issue(1, ok);
      exp = sb.pop_front();
      got = obs();
      n_tests++;
      if (!ok || got !== exp) begin
        n_fail++;
        $display("FAIL b2b_order_%0d: fired=%b got %h, required %h", k, ok, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_zero_operand();
    bit   ok;
    rec_t exp, got;
    bus.issue_ready = 1'b1;
    set_disp(MDU_OP_MULHSU, 0, 6, 0, 1, 1, 0, 23, 5);
    sb.push_back(mk(MDU_OP_MULHSU, 0, 6, 0, 0, 1, 0, 23, 5));
    tick();
    idle();
    wait_issue(1, ok);
    exp = sb.pop_front();
    got = obs();
    n_tests++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL zero_A: fired=%b got %h, required %h", ok, got, exp);
    end
    tick();
  endtask

  task automatic test_div_grouping();
    bit   ok;
    rec_t exp, got, r_mul, r_rem;
    bus.issue_ready = 1'b1;
    set_disp(MDU_OP_DIV, 7, 8, 1, 1, 0, 0, 24, 6);
    sb.push_back(mk(MDU_OP_DIV, 7, 8, 0, 0, 0, 0, 24, 6));
    tick();
    idle();
    wait_issue(1, ok);
    exp = sb.pop_front();
    got = obs();
    n_tests++;
    if (!ok || got !== exp) begin
      n_fail++;
      $display("FAIL grp_first_div: fired=%b got %h, required %h", ok, got, exp);
    end
    tick();
    bus.issue_ready = 1'b0;
    set_disp(MDU_OP_MUL, 1, 2, 1, 1, 0, 0, 25, 7);
    tick();
    set_disp(MDU_OP_REM, 7, 8, 1, 1, 0, 0, 26, 8);
    tick();
    idle();
    r_mul = mk(MDU_OP_MUL, 1, 2, 0, 0, 0, 0, 25, 7);
    r_rem = mk(MDU_OP_REM, 7, 8, 0, 0, 0, 0, 26, 8);
`ifdef MDU_IQ_DIV_GROUPING_EN
    sb.push_back(r_rem);
    sb.push_back(r_mul);
`else
    sb.push_back(r_mul);
    sb.push_back(r_rem);
`endif
    bus.issue_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_issue(1, ok);
      exp = sb.pop_front();
      got = obs();
      n_tests++;
      if (!ok || got !== exp) begin
        n_fail++;
        $display("FAIL grp_order_%0d: fired=%b got %h, required %h", k, ok, got, exp);
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul_basic();
    test_div_wakeup();
    test_full();
    test_back_to_back();
    test_zero_operand();
    test_div_grouping();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
